// File: rtl/fft_result_reorder.sv
// Ping-pong reorder buffer for a 16-point radix-2 FFT: accepts bit-reversed
// butterfly result pairs and re-emits the frame's 16 bins in natural order.
module fft_result_reorder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_en,
   input  logic [31:0] in_d0,
   input  logic [31:0] in_d1,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_idx,
   output logic        out_last,
   output logic        err_ovf
);

   function automatic logic [3:0] bitrev4(input logic [3:0] x);
      return {x[0], x[1], x[2], x[3]};
   endfunction

   logic [31:0] mem_r [2][16];
   logic        wbank_r;
   logic [2:0]  wcnt_r;
   logic        rbank_r;
   logic [3:0]  rcnt_r;
   logic [1:0]  full_r;
   logic        err_ovf_r;

   logic        wr_acc_s;
   logic        rd_acc_s;
   logic [1:0]  full_nxt_s;

   assign in_ready  = ~full_r[wbank_r];
   assign out_valid = full_r[rbank_r];
   assign out_data  = full_r[rbank_r] ? mem_r[rbank_r][rcnt_r] : 32'h0000_0000;
   assign out_idx   = rcnt_r;
   assign out_last  = full_r[rbank_r] && (rcnt_r == 4'd15);
   assign err_ovf   = err_ovf_r;

   assign wr_acc_s  = in_en && ~full_r[wbank_r];
   assign rd_acc_s  = out_ready && full_r[rbank_r];

   // Bank-full flags; a same-cycle set and clear always hit different banks.
   always_comb begin
      full_nxt_s = full_r;
      if (rd_acc_s && (rcnt_r == 4'd15)) begin
         full_nxt_s[rbank_r] = 1'b0;
      end else begin
         full_nxt_s[rbank_r] = full_r[rbank_r];
      end
      if (wr_acc_s && (wcnt_r == 3'd7)) begin
         full_nxt_s[wbank_r] = 1'b1;
      end else begin
         full_nxt_s[wbank_r] = full_nxt_s[wbank_r];
      end
   end

   // Sample storage; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (wr_acc_s) begin
         mem_r[wbank_r][bitrev4({wcnt_r, 1'b0})] <= in_d0;
         mem_r[wbank_r][bitrev4({wcnt_r, 1'b1})] <= in_d1;
      end
   end

   // Write/read pointers, bank flags and the sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wbank_r   <= 1'b0;
         wcnt_r    <= 3'd0;
         rbank_r   <= 1'b0;
         rcnt_r    <= 4'd0;
         full_r    <= 2'b00;
         err_ovf_r <= 1'b0;
      end else begin
         full_r <= full_nxt_s;
         if (wr_acc_s) begin
            wcnt_r <= wcnt_r + 3'd1;
            if (wcnt_r == 3'd7) begin
               wbank_r <= ~wbank_r;
            end
         end
         if (rd_acc_s) begin
            rcnt_r <= rcnt_r + 4'd1;
            if (rcnt_r == 4'd15) begin
               rbank_r <= ~rbank_r;
            end
         end
         if (in_en && full_r[wbank_r]) begin
            err_ovf_r <= 1'b1;
         end
      end
   end

endmodule
